// File: rtl/uart_const_pkg.sv
// Shared constants and state encodings for the UART receive path and message checker.
package uart_const_pkg;
   localparam int   UART_DATA_BITS = 8;
   localparam logic UART_IDLE_LVL  = 1'b1;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {CK_IDLE, CK_ALIGN, CK_WAIT, CK_FINISH} ck_state_t;
endpackage

// File: rtl/uart_rx_deser.sv
// Oversampled 8N1 deserialiser: 2-FF synchroniser, start-edge detect, mid-bit sampling.
module uart_rx_deser
   import uart_const_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       RXD,
   output logic       BYTE_VALID,
   output logic [7:0] BYTE_DATA,
   output logic       FRAME_ERR
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE/2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
   localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

   // sync[1] is the synchronised line, sync[2] its previous value for edge detect
   logic [2:0]          sync;
   rx_state_t           state;
   logic [CW-1:0]       tick;
   logic [2:0]          bit_idx;
   logic [7:0]          shreg;
   logic                rx;
   logic                fall;

   assign rx   = sync[1];
   assign fall = sync[2] & ~sync[1];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync       <= {3{UART_IDLE_LVL}};
         state      <= RX_IDLE;
         tick       <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         BYTE_VALID <= 1'b0;
         BYTE_DATA  <= '0;
         FRAME_ERR  <= 1'b0;
      end else begin
         sync       <= {sync[1:0], RXD};
         BYTE_VALID <= 1'b0;
         FRAME_ERR  <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (fall) begin
                  state <= RX_START;
                  tick  <= '0;
               end
            end
            RX_START: begin
               if (tick == HALF_M1) begin
                  tick    <= '0;
                  bit_idx <= '0;
                  state   <= rx ? RX_IDLE : RX_DATA;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            RX_DATA: begin
               if (tick == FULL_M1) begin
                  tick  <= '0;
                  shreg <= {rx, shreg[7:1]};
                  if (bit_idx == LAST_BIT) state <= RX_STOP;
                  else                     bit_idx <= bit_idx + 1'b1;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            RX_STOP: begin
               if (tick == FULL_M1) begin
                  tick       <= '0;
                  BYTE_VALID <= 1'b1;
                  BYTE_DATA  <= shreg;
                  FRAME_ERR  <= ~rx;
                  state      <= RX_IDLE;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/uart_msg_checker.sv
// Serial monitor that compares received UART bytes against an expected message string.
module uart_msg_checker
   import uart_const_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int MSG_BYTES  = 128,
   parameter int CNT_W      = 16
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   RXD,
   input  logic [MSG_BYTES*8-1:0] EXP_MSG,
   input  logic                   START,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   PASS,
   output logic                   BYTE_VALID,
   output logic [7:0]             BYTE_DATA,
   output logic                   FRAME_ERR,
   output logic [CNT_W-1:0]       ERR_CNT,
   output logic [CNT_W-1:0]       BYTE_CNT
);
   localparam int MW = MSG_BYTES*8;
   localparam int AW = $clog2(MSG_BYTES + 1);

   ck_state_t         state;
   logic [MW-1:0]     msg;
   logic [MW-1:0]     msg_sh;
   logic [AW-1:0]     align_cnt;
   logic [7:0]        top_byte;
   logic [7:0]        next_byte;
   logic              mismatch;
   logic [CNT_W-1:0]  err_inc;
   logic [CNT_W-1:0]  cnt_inc;

   uart_rx_deser #(.OVERSAMPLE(OVERSAMPLE)) u_rx (
      .CLK        (CLK),
      .RESET      (RESET),
      .RXD        (RXD),
      .BYTE_VALID (BYTE_VALID),
      .BYTE_DATA  (BYTE_DATA),
      .FRAME_ERR  (FRAME_ERR)
   );

   assign msg_sh    = msg << 8;
   assign top_byte  = msg[MW-1 -: 8];
   assign next_byte = msg_sh[MW-1 -: 8];
   assign mismatch  = (BYTE_DATA != top_byte) | FRAME_ERR;
   assign err_inc   = (&ERR_CNT)  ? ERR_CNT  : ERR_CNT  + CNT_W'(1);
   assign cnt_inc   = (&BYTE_CNT) ? BYTE_CNT : BYTE_CNT + CNT_W'(1);

   // DONE/PASS/BUSY are registered on entry to FINISH so they are visible during that cycle
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= CK_IDLE;
         msg       <= '0;
         align_cnt <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         PASS      <= 1'b0;
         ERR_CNT   <= '0;
         BYTE_CNT  <= '0;
      end else begin
         DONE <= 1'b0;
         case (state)
            CK_IDLE: begin
               if (START) begin
                  msg       <= EXP_MSG;
                  align_cnt <= '0;
                  ERR_CNT   <= '0;
                  BYTE_CNT  <= '0;
                  PASS      <= 1'b0;
                  BUSY      <= 1'b1;
                  state     <= CK_ALIGN;
               end
            end
            CK_ALIGN: begin
               if (msg == '0 || align_cnt == AW'(MSG_BYTES)) begin
                  DONE  <= 1'b1;
                  PASS  <= (ERR_CNT == '0);
                  BUSY  <= 1'b0;
                  state <= CK_FINISH;
               end else if (top_byte != 8'h00) begin
                  state <= CK_WAIT;
               end else begin
                  msg       <= msg_sh;
                  align_cnt <= align_cnt + 1'b1;
               end
            end
            CK_WAIT: begin
               if (BYTE_VALID) begin
                  BYTE_CNT <= cnt_inc;
                  if (mismatch) ERR_CNT <= err_inc;
                  msg <= msg_sh;
                  if (next_byte == 8'h00) begin
                     DONE  <= 1'b1;
                     PASS  <= mismatch ? (err_inc == '0) : (ERR_CNT == '0);
                     BUSY  <= 1'b0;
                     state <= CK_FINISH;
                  end
               end
            end
            CK_FINISH: state <= CK_IDLE;
            default:   state <= CK_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_msg_checker.sv
// Directed bench: table of message checks plus hand-written glitch, reset and zero-message sequences.
module tb_uart_msg_checker;
   localparam int OS = 16;
   localparam int MB = 128;
   localparam int CW = 16;

   logic            CLK = 1'b0;
   logic            RESET = 1'b1;
   logic            RXD = 1'b1;
   logic [MB*8-1:0] EXP_MSG = '0;
   logic            START = 1'b0;
   logic            BUSY, DONE, PASS, BYTE_VALID, FRAME_ERR;
   logic [7:0]      BYTE_DATA;
   logic [CW-1:0]   ERR_CNT, BYTE_CNT;

   uart_msg_checker #(.OVERSAMPLE(OS), .MSG_BYTES(MB), .CNT_W(CW)) dut (
      .CLK(CLK), .RESET(RESET), .RXD(RXD), .EXP_MSG(EXP_MSG), .START(START),
      .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .BYTE_VALID(BYTE_VALID),
      .BYTE_DATA(BYTE_DATA), .FRAME_ERR(FRAME_ERR), .ERR_CNT(ERR_CNT), .BYTE_CNT(BYTE_CNT)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0, bv_n = 0, fe_n = 0, done_n = 0, bv_cyc = 0, done_cyc = 0;
   logic [7:0] last_data = 8'h00;

   always @(negedge CLK) begin
      cyc = cyc + 1;
      if (BYTE_VALID) begin bv_n = bv_n + 1; bv_cyc = cyc; last_data = BYTE_DATA; end
      if (FRAME_ERR) fe_n = fe_n + 1;
      if (DONE) begin done_n = done_n + 1; done_cyc = cyc; end
   end

   typedef struct {
      logic [15:0] msg;
      int          n;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic        stop_ok;
      logic        pass;
      int          err;
      int          fe;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic drive_bit(input logic b);
      RXD = b;
      cycles(OS);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop);
      drive_bit(1'b1);
      drive_bit(1'b1);
   endtask

   task automatic pulse_start();
      START = 1'b1;
      cycles(1);
      START = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int limit, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (done_n > d0) begin seen = 1'b1; break; end
         cycles(1);
      end
      if (done_n > d0) seen = 1'b1;
   endtask

   initial begin
      int   bv0, d0, fe0;
      logic seen;

      vecs[0] = '{msg: 16'h4869, n: 2, b0: 8'h48, b1: 8'h69, stop_ok: 1'b1, pass: 1'b1, err: 0, fe: 0};
      vecs[1] = '{msg: 16'h4869, n: 2, b0: 8'h48, b1: 8'h6A, stop_ok: 1'b1, pass: 1'b0, err: 1, fe: 0};
      vecs[2] = '{msg: 16'h0041, n: 1, b0: 8'h41, b1: 8'h00, stop_ok: 1'b0, pass: 1'b0, err: 1, fe: 1};
      vecs[3] = '{msg: 16'h4869, n: 2, b0: 8'h49, b1: 8'h68, stop_ok: 1'b1, pass: 1'b0, err: 2, fe: 0};

      // reset state
      cycles(3);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_pass", PASS, 0);
      chk("rst_bv", BYTE_VALID, 0);
      chk("rst_data", BYTE_DATA, 0);
      chk("rst_fe", FRAME_ERR, 0);
      chk("rst_err", ERR_CNT, 0);
      chk("rst_cnt", BYTE_CNT, 0);
      RESET = 1'b0;
      cycles(4);

      for (int v = 0; v < 4; v++) begin
         EXP_MSG = '0;
         EXP_MSG[15:0] = vecs[v].msg;
         pulse_start();
         chk($sformatf("v%0d_busy", v), BUSY, 1);
         cycles(MB + 4);
         bv0 = bv_n; d0 = done_n; fe0 = fe_n;
         send_byte(vecs[v].b0, vecs[v].stop_ok);
         chk($sformatf("v%0d_b0", v), last_data, vecs[v].b0);
         if (vecs[v].n == 2) begin
            send_byte(vecs[v].b1, 1'b1);
            chk($sformatf("v%0d_b1", v), last_data, vecs[v].b1);
         end
         wait_done(d0, 50, seen);
         chk($sformatf("v%0d_done", v), seen, 1);
         chk($sformatf("v%0d_bvn", v), bv_n - bv0, vecs[v].n);
         chk($sformatf("v%0d_done_lat", v), done_cyc - bv_cyc, 1);
         chk($sformatf("v%0d_pass", v), PASS, vecs[v].pass);
         chk($sformatf("v%0d_errcnt", v), ERR_CNT, vecs[v].err);
         chk($sformatf("v%0d_bytecnt", v), BYTE_CNT, vecs[v].n);
         chk($sformatf("v%0d_fe", v), fe_n - fe0, vecs[v].fe);
         chk($sformatf("v%0d_busy_end", v), BUSY, 0);
         cycles(20);
      end

      // glitch shorter than half a bit is a false start
      bv0 = bv_n;
      RXD = 1'b0; cycles(4); RXD = 1'b1; cycles(40);
      chk("glitch_none", bv_n - bv0, 0);
      send_byte(8'h55, 1'b1);
      chk("glitch_bvn", bv_n - bv0, 1);
      chk("glitch_data", last_data, 8'h55);

      // reset mid-frame during an armed check
      EXP_MSG = '0;
      EXP_MSG[15:0] = 16'h4869;
      pulse_start();
      cycles(MB + 4);
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b0);
      RESET = 1'b1; RXD = 1'b1;
      cycles(1);
      RESET = 1'b0;
      chk("mrst_busy", BUSY, 0);
      chk("mrst_data", BYTE_DATA, 0);
      chk("mrst_pass", PASS, 0);
      chk("mrst_cnt", BYTE_CNT, 0);
      cycles(40);
      bv0 = bv_n; d0 = done_n;
      send_byte(8'h48, 1'b1);
      chk("mrst_bvn", bv_n - bv0, 1);
      chk("mrst_data2", last_data, 8'h48);
      chk("mrst_nodone", done_n - d0, 0);
      chk("mrst_cnt2", BYTE_CNT, 0);

      // all-zero message finishes immediately
      EXP_MSG = '0;
      d0 = done_n;
      pulse_start();
      wait_done(d0, MB + 2, seen);
      chk("zero_done", seen, 1);
      cycles(1);
      chk("zero_pass", PASS, 1);
      chk("zero_cnt", BYTE_CNT, 0);
      chk("zero_busy", BUSY, 0);

      // START while busy is ignored
      EXP_MSG = '0;
      EXP_MSG[15:0] = 16'h4869;
      pulse_start();
      cycles(MB + 4);
      d0 = done_n;
      send_byte(8'h48, 1'b1);
      EXP_MSG = '0;
      EXP_MSG[7:0] = 8'h5A;
      pulse_start();
      chk("rearm_cnt", BYTE_CNT, 1);
      send_byte(8'h69, 1'b1);
      wait_done(d0, 50, seen);
      chk("rearm_done", seen, 1);
      chk("rearm_pass", PASS, 1);
      chk("rearm_err", ERR_CNT, 0);
      chk("rearm_bytecnt", BYTE_CNT, 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
